irda_sir_codec: RTL and testbench

IRDA_SIR_CODEC -- requirements
Module: irda_sir_codec

---
 rtl/irda_sir_codec_pkg.sv | 14 +
 rtl/irda_sir_rx.sv | 69 ++++++
 rtl/irda_sir_codec.sv | 86 ++++++++
 tb/tb_irda_sir_codec.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/irda_sir_codec_pkg.sv
// irda_sir_codec_pkg: shared parameter defaults, encoder state encoding and counter sizing
package irda_sir_codec_pkg;
    localparam int DEF_BIT_CLKS    = 432;
    localparam int DEF_PULSE_CLKS  = 81;
    localparam int DEF_GLITCH_CLKS = 4;
    localparam int DEF_IDLE_CELLS  = 10;
    localparam int DEF_ECHO_CLKS   = 432;

    typedef enum logic {TX_IDLE = 1'b0, TX_ACTIVE = 1'b1} tx_state_t;

    function automatic int cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/irda_sir_rx.sv
// irda_sir_rx: IrDA SIR decoder -- synchronizer, glitch filter, bit-cell stretch and echo blanking
module irda_sir_rx import irda_sir_codec_pkg::*; #(
    parameter int BIT_CLKS    = DEF_BIT_CLKS,
    parameter int GLITCH_CLKS = DEF_GLITCH_CLKS,
    parameter int ECHO_CLKS   = DEF_ECHO_CLKS
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    input  logic ir_rx,
    input  logic tx_busy,
    output logic rxd
);
    localparam int SW = cw(BIT_CLKS);
    localparam int GW = cw(GLITCH_CLKS);
    localparam int EW = cw(ECHO_CLKS);

    logic [1:0]    sync;
    logic [GW-1:0] low_cnt;
    logic [EW-1:0] echo_cnt;
    logic [SW-1:0] str_cnt;
    logic          hit, acc, echo_on, low_done, blank;

    // hit marks a pulse already consumed (accepted or blanked) until the line returns high
    assign low_done = !sync[1] && low_cnt == GW'(GLITCH_CLKS - 1) && !hit;
    assign blank    = tx_busy || echo_on;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync     <= 2'b11;
            low_cnt  <= '0;
            hit      <= 1'b0;
            acc      <= 1'b0;
            echo_on  <= 1'b0;
            echo_cnt <= '0;
            str_cnt  <= '0;
            rxd      <= 1'b1;
        end else begin
            sync <= {sync[0], ir_rx};
            if (!en) begin
                low_cnt  <= '0;
                hit      <= 1'b0;
                acc      <= 1'b0;
                echo_on  <= 1'b0;
                echo_cnt <= '0;
                str_cnt  <= '0;
                rxd      <= 1'b1;
            end else begin
                low_cnt <= sync[1] ? '0 : (low_cnt == GW'(GLITCH_CLKS - 1)) ? low_cnt : low_cnt + 1'b1;
                hit     <= sync[1] ? 1'b0 : (hit || low_done);
                acc     <= low_done && !blank;
                if (tx_busy) begin
                    echo_on  <= 1'b1;
                    echo_cnt <= EW'(ECHO_CLKS - 1);
                end else if (echo_on) begin
                    if (echo_cnt == '0) echo_on <= 1'b0;
                    else echo_cnt <= echo_cnt - 1'b1;
                end
                if (acc) begin
                    rxd     <= 1'b0;
                    str_cnt <= SW'(BIT_CLKS - 1);
                end else if (!rxd) begin
                    if (str_cnt == '0) rxd <= 1'b1;
                    else str_cnt <= str_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/irda_sir_codec.sv
// irda_sir_codec: IrDA SIR encoder (NRZ txd -> 3/16-bit IR pulses) with the irda_sir_rx decoder
module irda_sir_codec import irda_sir_codec_pkg::*; #(
    parameter int BIT_CLKS    = DEF_BIT_CLKS,
    parameter int PULSE_CLKS  = DEF_PULSE_CLKS,
    parameter int GLITCH_CLKS = DEF_GLITCH_CLKS,
    parameter int IDLE_CELLS  = DEF_IDLE_CELLS,
    parameter int ECHO_CLKS   = DEF_ECHO_CLKS
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    input  logic txd,
    output logic ir_tx,
    input  logic ir_rx,
    output logic rxd,
    output logic tx_busy
);
    localparam int CW = cw(BIT_CLKS);
    localparam int PW = cw(PULSE_CLKS);
    localparam int HW = cw(IDLE_CELLS);

    tx_state_t     state;
    logic          txd_q, start_fall, cell_start;
    logic [CW-1:0] cell_cnt;
    logic [PW-1:0] pulse_cnt;
    logic [HW-1:0] hi_cnt;

    assign start_fall = state == TX_IDLE && txd_q && !txd;
    assign cell_start = start_fall || (state == TX_ACTIVE && cell_cnt == CW'(BIT_CLKS - 1));
    assign tx_busy    = state == TX_ACTIVE;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= TX_IDLE;
            txd_q     <= 1'b1;
            cell_cnt  <= '0;
            pulse_cnt <= '0;
            hi_cnt    <= '0;
            ir_tx     <= 1'b0;
        end else if (!en) begin
            state     <= TX_IDLE;
            txd_q     <= txd;
            cell_cnt  <= '0;
            pulse_cnt <= '0;
            hi_cnt    <= '0;
            ir_tx     <= 1'b0;
        end else begin
            txd_q <= txd;
            if (cell_start) begin
                cell_cnt <= '0;
                if (!txd) begin
                    state  <= TX_ACTIVE;
                    hi_cnt <= '0;
                end else if (hi_cnt == HW'(IDLE_CELLS - 1)) begin
                    state  <= TX_IDLE;
                    hi_cnt <= '0;
                end else begin
                    hi_cnt <= hi_cnt + 1'b1;
                end
            end else if (state == TX_ACTIVE) begin
                cell_cnt <= cell_cnt + 1'b1;
            end
            // pulse length is fixed at its start; txd is only looked at on cell starts
            if (cell_start && !txd) begin
                ir_tx     <= 1'b1;
                pulse_cnt <= PW'(PULSE_CLKS - 1);
            end else if (ir_tx) begin
                if (pulse_cnt == '0) ir_tx <= 1'b0;
                else pulse_cnt <= pulse_cnt - 1'b1;
            end
        end
    end

    irda_sir_rx #(
        .BIT_CLKS   (BIT_CLKS),
        .GLITCH_CLKS(GLITCH_CLKS),
        .ECHO_CLKS  (ECHO_CLKS)
    ) u_rx (
        .clk    (clk),
        .nreset (nreset),
        .en     (en),
        .ir_rx  (ir_rx),
        .tx_busy(tx_busy),
        .rxd    (rxd)
    );
endmodule

// File: tb/tb_irda_sir_codec.sv
// tb_irda_sir_codec: edge scoreboard for ir_tx, rxd and tx_busy against hand-derived cycle times
module tb_irda_sir_codec;
    localparam int BIT = 432;
    localparam int PUL = 81;

    typedef struct {int cyc; logic val;} ev_t;

    logic clk = 1'b0, nreset = 1'b0, en = 1'b1, txd = 1'b1, ir_rx = 1'b1;
    logic ir_tx, rxd, tx_busy;
    logic p_tx = 1'b0, p_rx = 1'b1, p_bz = 1'b0, mon_on = 1'b0;
    int   cyc = 0, tests = 0, fails = 0;
    ev_t  q_tx[$], q_rx[$], q_bz[$];

    irda_sir_codec dut (
        .clk    (clk),
        .nreset (nreset),
        .en     (en),
        .txd    (txd),
        .ir_tx  (ir_tx),
        .ir_rx  (ir_rx),
        .rxd    (rxd),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", n, got, exp);
        end
    endtask

    task automatic chk_ev(input string n, input ev_t e, input logic v, input int c, input int tol);
        tests++;
        if (v !== e.val || c - e.cyc > tol || e.cyc - c > tol) begin
            fails++;
            $display("FAIL %s edge: got %b at cycle %0d, expected %b at cycle %0d", n, v, c, e.val, e.cyc);
        end
    endtask

    task automatic unexp(input string n, input logic v);
        tests++;
        fails++;
        $display("FAIL %s edge: got unexpected %b at cycle %0d, expected no change", n, v, cyc);
    endtask

    // monitor: every output edge is matched against the head of that output's queue
    always @(negedge clk) begin
        if (mon_on) begin
            if (ir_tx !== p_tx) begin
                if (q_tx.size() == 0) unexp("ir_tx", ir_tx);
                else chk_ev("ir_tx", q_tx.pop_front(), ir_tx, cyc, 1);
            end
            if (rxd !== p_rx) begin
                if (q_rx.size() == 0) unexp("rxd", rxd);
                else chk_ev("rxd", q_rx.pop_front(), rxd, cyc, 0);
            end
            if (tx_busy !== p_bz) begin
                if (q_bz.size() == 0) unexp("tx_busy", tx_busy);
                else chk_ev("tx_busy", q_bz.pop_front(), tx_busy, cyc, 0);
            end
        end
        p_tx = ir_tx;
        p_rx = rxd;
        p_bz = tx_busy;
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // cell k is sampled at s+BIT*k; encoder idles on the 10th consecutive high cell
    task automatic push_frame(input logic [9:0] b, input int s, output int fall);
        int hi = 0;
        int c = 0;
        q_bz.push_back('{s, 1'b1});
        for (int k = 0; k < 10; k++)
            if (!b[k]) begin
                q_tx.push_back('{s + BIT * k, 1'b1});
                q_tx.push_back('{s + BIT * k + PUL, 1'b0});
            end
        fall = 0;
        while (fall == 0) begin
            hi = (c >= 10 || b[c]) ? hi + 1 : 0;
            if (hi == 10) fall = s + BIT * c;
            c++;
        end
        q_bz.push_back('{fall, 1'b0});
    endtask

    task automatic send(input logic [9:0] b, output int fall);
        int s = cyc + 1;
        push_frame(b, s, fall);
        for (int k = 0; k < 10; k++) begin
            txd = b[k];
            repeat (BIT) @(negedge clk);
        end
        txd = 1'b1;
        wait_cyc(fall + 5);
    endtask

    // pulse begins at the current negedge; accepted pulses drop rxd 7 posedges later
    task automatic rx_pulse(input int len, input logic accept);
        if (accept) begin
            q_rx.push_back('{cyc + 7, 1'b0});
            q_rx.push_back('{cyc + 7 + BIT, 1'b1});
        end
        ir_rx = 1'b0;
        repeat (len) @(negedge clk);
        ir_rx = 1'b1;
    endtask

    initial begin
        int f, n;
        repeat (3) @(negedge clk);
        chk("reset ir_tx", ir_tx, 1'b0);
        chk("reset rxd", rxd, 1'b1);
        chk("reset tx_busy", tx_busy, 1'b0);
        nreset = 1'b1;
        @(negedge clk);
        mon_on = 1'b1;
        repeat (5) @(negedge clk);

        rx_pulse(3, 1'b0);
        repeat (20) @(negedge clk);
        rx_pulse(PUL, 1'b1);
        wait_cyc(cyc + BIT + 20);

        n = cyc;
        q_rx.push_back('{n + 7, 1'b0});
        q_rx.push_back('{n + 7 + 2 * BIT, 1'b1});
        ir_rx = 1'b0;
        repeat (PUL) @(negedge clk);
        ir_rx = 1'b1;
        wait_cyc(n + BIT);
        ir_rx = 1'b0;
        repeat (PUL) @(negedge clk);
        ir_rx = 1'b1;
        wait_cyc(n + 2 * BIT + 20);

        send(10'b1100101100, f);
        repeat (10) @(negedge clk);

        fork
            send({1'b1, 8'hFF, 1'b0}, f);
            begin
                repeat (1000) @(negedge clk);
                rx_pulse(PUL, 1'b0);
            end
        join
        wait_cyc(f + 200);
        rx_pulse(PUL, 1'b0);
        wait_cyc(f + 433);
        rx_pulse(PUL, 1'b1);
        wait_cyc(f + 433 + BIT + 20);

        n = cyc;
        q_tx.push_back('{n + 1, 1'b1});
        q_bz.push_back('{n + 1, 1'b1});
        txd = 1'b0;
        wait_cyc(n + 21);
        q_tx.push_back('{n + 22, 1'b0});
        q_bz.push_back('{n + 22, 1'b0});
        en = 1'b0;
        txd = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (10) @(negedge clk);

        n = cyc;
        q_tx.push_back('{n + 1, 1'b1});
        q_bz.push_back('{n + 1, 1'b1});
        txd = 1'b0;
        while (cyc < n + 41) @(posedge clk);
        #2;
        q_tx.push_back('{cyc, 1'b0});
        q_bz.push_back('{cyc, 1'b0});
        nreset = 1'b0;
        #1;
        chk("async reset ir_tx", ir_tx, 1'b0);
        chk("async reset tx_busy", tx_busy, 1'b0);
        chk("async reset rxd", rxd, 1'b1);
        @(negedge clk);
        txd = 1'b1;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (5) @(negedge clk);
        send({1'b1, 8'h55, 1'b0}, f);
        repeat (10) @(negedge clk);

        tests++;
        if (q_tx.size() != 0) begin
            fails++;
            $display("FAIL ir_tx pending: got %0d edges missing, expected 0", q_tx.size());
        end
        tests++;
        if (q_rx.size() != 0) begin
            fails++;
            $display("FAIL rxd pending: got %0d edges missing, expected 0", q_rx.size());
        end
        tests++;
        if (q_bz.size() != 0) begin
            fails++;
            $display("FAIL tx_busy pending: got %0d edges missing, expected 0", q_bz.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
